// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: datapath width, ALU opcodes and the
// multiply-sequencing FSM encoding.
package execute_stage_pkg;
  localparam int XLEN        = 64;
  localparam int MUL_RADIX_B = 4;
  localparam int MUL_STEPS   = XLEN / MUL_RADIX_B;
  localparam int MUL_CNT_W   = $clog2(MUL_STEPS);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_LSL   = 4'b1000;
  localparam logic [3:0] ALU_LSR   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_DONE = 2'd2
  } ex_state_e;
endpackage

// File: rtl/execute_stage_mul.sv
// Iterative shift-add multiplier: retires MUL_RADIX_B multiplier bits per cycle,
// producing the low XLEN bits of a*b after MUL_STEPS cycles.
module iter_multiplier
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  logic [XLEN-1:0]      mcand;
  logic [XLEN-1:0]      mplier;
  logic [XLEN-1:0]      pp_sum;
  logic [MUL_CNT_W-1:0] count;

  always_comb begin
    pp_sum = product;
    for (int i = 0; i < MUL_RADIX_B; i++) begin
      if (mplier[i]) pp_sum = pp_sum + (mcand << i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      product <= '0;
      count   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (busy) begin
      product <= pp_sum;
      mcand   <= mcand << MUL_RADIX_B;
      mplier  <= mplier >> MUL_RADIX_B;
      count   <= count + 1'b1;
      if (count == MUL_CNT_W'(MUL_STEPS - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: ALU, branch-target adder, zero flag and EX/MEM register,
// with an iterative multiply that holds off ID until its result is registered.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rdata1_i,
  input  logic [XLEN-1:0] rdata2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [3:0]      alu_op_i,
  input  logic            alu_src_i,
  input  logic            b_i,
  input  logic            bz_i,
  input  logic            bnz_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            mem_to_reg_i,
  input  logic            reg_write_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] branch_addr_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] data2_o,
  output logic            zero_o,
  output logic            b_o,
  output logic            bz_o,
  output logic            bnz_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            reg_write_o,
  output logic [1:0]      state_dbg
);
  ex_state_e       state;
  logic            accept;
  logic            is_mul;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] baddr;
  logic [6:0]      in_ctrl;
  logic [6:0]      ctrl_q;
  // Bundle captured at MUL accept so MEM later sees instr/controls matching the product.
  logic [31:0]     h_instr;
  logic [XLEN-1:0] h_baddr;
  logic [XLEN-1:0] h_data2;
  logic [6:0]      h_ctrl;

  // Handshake: an instruction transfers on a rising edge where valid_i & ready_o;
  // ready_o depends only on FSM state and stall_i, never on valid_i.
  assign ready_o   = (state == ST_IDLE) && !stall_i;
  assign accept    = valid_i && ready_o;
  assign is_mul    = (alu_op_i == ALU_MUL);
  assign mul_start = accept && is_mul && !flush_i;
  assign op_b      = alu_src_i ? imm_i : rdata2_i;
  assign baddr     = pc_i + (imm_i << 2);
  assign in_ctrl   = {b_i, bz_i, bnz_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i};
  assign {b_o, bz_o, bnz_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o} = ctrl_q;
  assign state_dbg = state;

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      ALU_AND:   alu_res = rdata1_i & op_b;
      ALU_ORR:   alu_res = rdata1_i | op_b;
      ALU_ADD:   alu_res = rdata1_i + op_b;
      ALU_SUB:   alu_res = rdata1_i - op_b;
      ALU_PASSB: alu_res = op_b;
      ALU_NOR:   alu_res = ~(rdata1_i | op_b);
      ALU_LSL:   alu_res = rdata1_i << op_b[5:0];
      ALU_LSR:   alu_res = rdata1_i >> op_b[5:0];
      default:   alu_res = '0;
    endcase
  end

  iter_multiplier u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (flush_i),
    .a       (rdata1_i),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      valid_o       <= 1'b0;
      ctrl_q        <= '0;
      instr_o       <= '0;
      branch_addr_o <= '0;
      result_o      <= '0;
      data2_o       <= '0;
      zero_o        <= 1'b0;
      h_instr       <= '0;
      h_baddr       <= '0;
      h_data2       <= '0;
      h_ctrl        <= '0;
    end else if (flush_i) begin
      state   <= ST_IDLE;
      valid_o <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && is_mul) begin
            state   <= ST_MUL_BUSY;
            h_instr <= instr_i;
            h_baddr <= baddr;
            h_data2 <= rdata2_i;
            h_ctrl  <= in_ctrl;
            valid_o <= 1'b0;
            ctrl_q  <= '0;
          end else if (accept) begin
            valid_o       <= 1'b1;
            ctrl_q        <= in_ctrl;
            instr_o       <= instr_i;
            branch_addr_o <= baddr;
            result_o      <= alu_res;
            data2_o       <= rdata2_i;
            zero_o        <= (alu_res == '0);
          end else if (!stall_i) begin
            valid_o <= 1'b0;
            ctrl_q  <= '0;
          end
        end
        ST_MUL_BUSY: begin
          if (!mul_busy && mul_done) state <= ST_MUL_DONE;
          if (!stall_i) begin
            valid_o <= 1'b0;
            ctrl_q  <= '0;
          end
        end
        ST_MUL_DONE: begin
          if (!stall_i) begin
            state         <= ST_IDLE;
            valid_o       <= 1'b1;
            ctrl_q        <= h_ctrl;
            instr_o       <= h_instr;
            branch_addr_o <= h_baddr;
            result_o      <= mul_product;
            data2_o       <= h_data2;
            zero_o        <= (mul_product == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed instructions push expected EX/MEM bundles,
// a negedge monitor pops and compares whenever a new live bundle is registered.
module tb_execute_stage;
  localparam int EW = 32 + 3 * 64 + 8;

  logic        clk, reset, valid_i, ready_o, alu_src_i;
  logic [31:0] instr_i, instr_o;
  logic [63:0] pc_i, rdata1_i, rdata2_i, imm_i;
  logic [3:0]  alu_op_i;
  logic        b_i, bz_i, bnz_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
  logic        stall_i, flush_i, valid_o, zero_o;
  logic [63:0] branch_addr_o, result_o, data2_o;
  logic        b_o, bz_o, bnz_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o;
  logic [1:0]  state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic ld_seen;

  execute_stage dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .imm_i(imm_i), .alu_op_i(alu_op_i), .alu_src_i(alu_src_i),
    .b_i(b_i), .bz_i(bz_i), .bnz_i(bnz_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .instr_o(instr_o),
    .branch_addr_o(branch_addr_o), .result_o(result_o), .data2_o(data2_o),
    .zero_o(zero_o), .b_o(b_o), .bz_o(bz_o), .bnz_o(bnz_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] mk(input logic [31:0] ins, input logic [63:0] ba,
                                       input logic [63:0] res, input logic [63:0] d2,
                                       input logic [6:0] ctl);
    return {ins, ba, res, d2, (res == 64'd0), ctl};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Driver: present one instruction, hold it until accepted (bounded), push expectation.
  task automatic issue(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] a,
                       input logic [63:0] d2, input logic [63:0] imm, input logic [3:0] op,
                       input logic src, input logic [6:0] ctl, input logic expect_out,
                       input logic [63:0] exp_res, input logic [63:0] exp_ba);
    int n;
    instr_i = ins; pc_i = pc; rdata1_i = a; rdata2_i = d2; imm_i = imm;
    alu_op_i = op; alu_src_i = src;
    {b_i, bz_i, bnz_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i} = ctl;
    valid_i = 1'b1;
    n = 0;
    forever begin
      #1;
      if (ready_o || n >= 60) break;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ready_o) begin
      failures++;
      $display("FAIL accept_timeout instr=%h got=ready_low required=ready_high", ins);
      valid_i = 1'b0;
    end else begin
      if (expect_out) exp_q.push_back(mk(ins, exp_ba, exp_res, d2, ctl));
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) ld_seen <= !stall_i || flush_i || reset;

  always @(negedge clk) begin
    logic [EW-1:0] act, exp;
    if (!reset && valid_o && ld_seen) begin
      act = {instr_o, branch_addr_o, result_o, data2_o, zero_o,
             b_o, bz_o, bnz_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h required=no_valid", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL exmem_bundle got=%h required=%h", act, exp);
        end
      end
    end
  end

  initial begin
    int cnt;
    reset = 1'b1; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    instr_i = '0; pc_i = '0; rdata1_i = '0; rdata2_i = '0; imm_i = '0;
    alu_op_i = '0; alu_src_i = 1'b0;
    {b_i, bz_i, bnz_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ctrl", 64'({b_o, bz_o, bnz_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o}), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_state", 64'(state_dbg), 64'd0);
    @(negedge clk);

    // ADD imm, then a bubble cycle
    issue(32'h8B00_0001, 64'h100, 64'd5, 64'h99, 64'd7, 4'b0010, 1'b1, 7'b0000001, 1'b1, 64'd12, 64'h11C);
    @(negedge clk);
    chk("bubble_valid", 64'(valid_o), 64'd0);
    chk("bubble_regwrite", 64'(reg_write_o), 64'd0);

    issue(32'hCB00_0002, 64'h200, 64'h1234, 64'h1234, 64'h10, 4'b0110, 1'b0, 7'b0100000, 1'b1, 64'd0, 64'h240);
    issue(32'h1400_0003, 64'h100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0111, 1'b1, 7'b1000000, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFC, 64'hF0);
    issue(32'h8A00_0004, 64'h10, 64'hF0F0, 64'hFF00, 64'h3FFF_FFFF_FFFF_FFFF, 4'b0000, 1'b0, 7'b0001011, 1'b1,
          64'hF000, 64'hC);
    issue(32'hAA00_0005, 64'h0, 64'h0F, 64'hF0, 64'd0, 4'b0001, 1'b0, 7'b0000001, 1'b1, 64'hFF, 64'h0);
    issue(32'hAA00_0006, 64'h8, 64'd0, 64'd0, 64'd1, 4'b1100, 1'b0, 7'b0000001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hC);
    issue(32'hD300_0007, 64'h0, 64'd1, 64'd0, 64'd63, 4'b1000, 1'b1, 7'b0000001, 1'b1, 64'h8000_0000_0000_0000, 64'hFC);
    issue(32'hD300_0008, 64'h0, 64'd3, 64'd0, 64'd65, 4'b1000, 1'b1, 7'b0000001, 1'b1, 64'd6, 64'h104);
    issue(32'hD340_0009, 64'h1000, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 4'b1001, 1'b1, 7'b0000001, 1'b1,
          64'd1, 64'h10FC);
    issue(32'hF800_000A, 64'h0, 64'h1000, 64'hDEAD_BEEF, 64'd8, 4'b0010, 1'b1, 7'b0010000, 1'b1, 64'h1008, 64'h20);
    issue(32'h0000_000B, 64'h0, 64'd5, 64'd3, 64'd0, 4'b0011, 1'b0, 7'b0000001, 1'b1, 64'd0, 64'h0);

    // MUL: latency and single result
    issue(32'h9B00_000C, 64'h400, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'b1010, 1'b0, 7'b0000001, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFD, 64'h408);
    cnt = 0;
    while (!ready_o && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt < 16 || cnt >= 100) begin
      failures++;
      $display("FAIL mul_ready_low_cycles got=%0d required=16..99", cnt);
    end
    repeat (2) @(negedge clk);

    // Stall after ADD: outputs frozen, next instruction waits
    issue(32'h8B00_000D, 64'h0, 64'd1, 64'd0, 64'd2, 4'b0010, 1'b1, 7'b0000001, 1'b1, 64'd3, 64'h8);
    stall_i = 1'b1;
    #1;
    chk("stall_ready", 64'(ready_o), 64'd0);
    fork
      issue(32'hAA00_000E, 64'h40, 64'h30, 64'h0C, 64'd0, 4'b0001, 1'b0, 7'b0000001, 1'b1, 64'h3C, 64'h40);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_result", result_o, 64'd3);
          chk("stall_valid", 64'(valid_o), 64'd1);
        end
        stall_i = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // MUL with stall spanning its completion
    issue(32'h9B00_000F, 64'h0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 4'b1010, 1'b0, 7'b0000011, 1'b1,
          64'hFFFF_FFFE_0000_0001, 64'h0);
    stall_i = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    chk("mul_stall_ready", 64'(ready_o), 64'd0);
    chk("mul_stall_valid", 64'(valid_o), 64'd0);
    stall_i = 1'b0;
    repeat (4) @(negedge clk);

    // Flush during MUL_BUSY: result must never appear
    issue(32'h9B00_0010, 64'h0, 64'd7, 64'd9, 64'd0, 4'b1010, 1'b0, 7'b0000001, 1'b0, 64'd63, 64'h0);
    repeat (3) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_ready", 64'(ready_o), 64'd1);
    chk("flush_state", 64'(state_dbg), 64'd0);
    repeat (30) @(negedge clk);

    // Reset mid-multiply
    issue(32'h9B00_0011, 64'h0, 64'd11, 64'd13, 64'd0, 4'b1010, 1'b0, 7'b0000001, 1'b0, 64'd143, 64'h0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midmul_reset_valid", 64'(valid_o), 64'd0);
    chk("midmul_reset_ready", 64'(ready_o), 64'd1);
    repeat (25) @(negedge clk);

    // Pipeline still healthy afterwards
    issue(32'h8B00_0012, 64'h8, 64'd40, 64'd2, 64'd0, 4'b0010, 1'b0, 7'b0000001, 1'b1, 64'd42, 64'h8);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
